// File: rtl/lsu_pkg.sv
// Types and sizing helpers shared by the load/store unit blocks.
package lsu_pkg;

  localparam int STQ_SIZE_DEFAULT = 32;
  localparam int STQ_IDX_W        = $clog2(STQ_SIZE_DEFAULT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

  function automatic int idx_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/stq_oldest_select.sv
// Find the oldest un-executed entry of a head-rotated queue and report whether it is ready.
module stq_oldest_select #(
  parameter int SIZE  = 32,
  parameter int IDX_W = 5
) (
  input  logic [SIZE-1:0]  rotated_valid,
  input  logic [SIZE-1:0]  rotated_executed,
  input  logic [SIZE-1:0]  rotated_committed,
  input  logic [SIZE-1:0]  rotated_address_valid,
  input  logic [SIZE-1:0]  rotated_data_valid,
  output logic             found,
  output logic [IDX_W-1:0] r,
  output logic             eligible
);

  logic [SIZE-1:0] pending;

  assign pending = rotated_valid & ~rotated_executed;

  // Scan from youngest to oldest so the last hit is the lowest rotated index.
  always_comb begin
    found = 1'b0;
    r     = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (pending[i]) begin
        found = 1'b1;
        r     = IDX_W'(i);
      end
    end
  end

  assign eligible = found & rotated_committed[r] & rotated_address_valid[r]
                  & rotated_data_valid[r];

endmodule

// File: rtl/store_fire_unit.sv
// Drains committed stores from the store queue to the data-memory write port, in order, one at a time.
module store_fire_unit
  import lsu_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ROB_TAG_WIDTH = 32,
  parameter int STQ_SIZE      = STQ_SIZE_DEFAULT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [STQ_SIZE-1:0]                    stq_valid,
  input  logic [STQ_SIZE-1:0]                    stq_rotated_valid,
  input  logic [STQ_SIZE-1:0]                    stq_rotated_executed,
  input  logic [STQ_SIZE-1:0]                    stq_rotated_committed,
  input  logic [STQ_SIZE-1:0]                    stq_rotated_address_valid,
  input  logic [STQ_SIZE-1:0]                    stq_rotated_data_valid,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]          stq_address,
  input  logic [STQ_SIZE-1:0][XLEN-1:0]          stq_data,
  input  logic [STQ_SIZE-1:0][ROB_TAG_WIDTH-1:0] stq_rob_tag,
  input  logic [$clog2(STQ_SIZE)-1:0]            head,
  output logic                                   mem_req_valid,
  input  logic                                   mem_req_ready,
  output logic [XLEN-1:0]                        mem_req_addr,
  output logic [XLEN-1:0]                        mem_req_data,
  input  logic                                   mem_resp_valid,
  output logic                                   store_fired,
  output logic [$clog2(STQ_SIZE)-1:0]            store_fired_index,
  output logic                                   store_succeeded,
  output logic [ROB_TAG_WIDTH-1:0]               store_succeeded_rob_tag,
  output logic                                   busy,
  output logic [XLEN-1:0]                        stores_retired
);

  localparam int IDX_W = idx_width(STQ_SIZE);

  lsu_state_e               state;
  logic                     sel_found;
  logic [IDX_W-1:0]         sel_r;
  logic                     sel_eligible;
  logic [IDX_W-1:0]         cand_idx;
  logic                     cand_ok;
  logic [IDX_W-1:0]         fire_idx;
  logic [ROB_TAG_WIDTH-1:0] fire_tag;

  stq_oldest_select #(
    .SIZE  (STQ_SIZE),
    .IDX_W (IDX_W)
  ) u_select (
    .rotated_valid         (stq_rotated_valid),
    .rotated_executed      (stq_rotated_executed),
    .rotated_committed     (stq_rotated_committed),
    .rotated_address_valid (stq_rotated_address_valid),
    .rotated_data_valid    (stq_rotated_data_valid),
    .found                 (sel_found),
    .r                     (sel_r),
    .eligible              (sel_eligible)
  );

  // Rotated position back to a physical slot; the IDX_W-bit add wraps naturally.
  assign cand_idx = head + sel_r;
  assign cand_ok  = sel_found & sel_eligible & stq_valid[cand_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      mem_req_valid           <= 1'b0;
      mem_req_addr            <= '0;
      mem_req_data            <= '0;
      fire_idx                <= '0;
      fire_tag                <= '0;
      store_succeeded         <= 1'b0;
      store_succeeded_rob_tag <= '0;
      stores_retired          <= '0;
    end else begin
      store_succeeded <= 1'b0;
      case (state)
        IDLE: begin
          if (cand_ok) begin
            fire_idx      <= cand_idx;
            fire_tag      <= stq_rob_tag[cand_idx];
            mem_req_addr  <= stq_address[cand_idx];
            mem_req_data  <= stq_data[cand_idx];
            mem_req_valid <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            store_succeeded         <= 1'b1;
            store_succeeded_rob_tag <= fire_tag;
            stores_retired          <= stores_retired + XLEN'(1);
            state                   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The fire pulse must coincide with the handshake so the queue marks the entry executed in time.
  assign store_fired       = mem_req_valid & mem_req_ready;
  assign store_fired_index = fire_idx;
  assign busy              = (state != IDLE);

endmodule

// File: tb/tb_store_fire_unit.sv
// Scoreboard bench: a store-queue model issues stores, a monitor checks program-order memory writes.
module tb_store_fire_unit;

  localparam int XLEN = 32;
  localparam int TW   = 8;
  localparam int N    = 8;
  localparam int IW   = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          stq_valid, stq_rotated_valid, stq_rotated_executed;
  logic [N-1:0]          stq_rotated_committed, stq_rotated_address_valid, stq_rotated_data_valid;
  logic [N-1:0][XLEN-1:0] stq_address, stq_data;
  logic [N-1:0][TW-1:0]  stq_rob_tag;
  logic [IW-1:0]         sq_head;
  logic                  mem_req_valid, mem_req_ready, mem_resp_valid;
  logic [XLEN-1:0]       mem_req_addr, mem_req_data, stores_retired;
  logic                  store_fired, store_succeeded, busy;
  logic [IW-1:0]         store_fired_index;
  logic [TW-1:0]         store_succeeded_rob_tag;

  always #5 clk = ~clk;

  store_fire_unit #(.XLEN(XLEN), .ROB_TAG_WIDTH(TW), .STQ_SIZE(N)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .stq_valid                 (stq_valid),
    .stq_rotated_valid         (stq_rotated_valid),
    .stq_rotated_executed      (stq_rotated_executed),
    .stq_rotated_committed     (stq_rotated_committed),
    .stq_rotated_address_valid (stq_rotated_address_valid),
    .stq_rotated_data_valid    (stq_rotated_data_valid),
    .stq_address               (stq_address),
    .stq_data                  (stq_data),
    .stq_rob_tag               (stq_rob_tag),
    .head                      (sq_head),
    .mem_req_valid             (mem_req_valid),
    .mem_req_ready             (mem_req_ready),
    .mem_req_addr              (mem_req_addr),
    .mem_req_data              (mem_req_data),
    .mem_resp_valid            (mem_resp_valid),
    .store_fired               (store_fired),
    .store_fired_index         (store_fired_index),
    .store_succeeded           (store_succeeded),
    .store_succeeded_rob_tag   (store_succeeded_rob_tag),
    .busy                      (busy),
    .stores_retired            (stores_retired)
  );

  // Store queue model, unrotated storage
  logic            m_v[N], m_ex[N], m_cm[N], m_av[N], m_dv[N];
  logic [XLEN-1:0] m_addr[N], m_data[N];
  logic [TW-1:0]   m_tag[N];
  int hd, tl, cnt;
  bit rdy, pending, hold_resp;
  int delay, spur_pct;

  typedef struct {
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [TW-1:0]   tag;
  } exp_t;
  exp_t          fire_q[$];
  logic [TW-1:0] tag_q[$];

  int checks = 0;
  int errors = 0;
  int mon_retired = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model(input int h);
    for (int i = 0; i < N; i++) begin
      m_v[i] = 0; m_ex[i] = 0; m_cm[i] = 0; m_av[i] = 0; m_dv[i] = 0;
      m_addr[i] = '0; m_data[i] = '0; m_tag[i] = '0;
    end
    hd = h; tl = h; cnt = 0; pending = 0;
    fire_q.delete();
  endtask

  task automatic alloc(input logic [XLEN-1:0] a, input logic [XLEN-1:0] d, input logic [TW-1:0] t,
                       input bit cm, input bit av, input bit dv);
    exp_t e;
    m_v[tl] = 1; m_ex[tl] = 0; m_cm[tl] = cm; m_av[tl] = av; m_dv[tl] = dv;
    m_addr[tl] = a; m_data[tl] = d; m_tag[tl] = t;
    e.idx = IW'(tl); e.addr = a; e.data = d; e.tag = t;
    fire_q.push_back(e);
    tl = (tl + 1) % N;
    cnt++;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      int j;
      j = (hd + i) % N;
      stq_rotated_valid[i]         = m_v[j];
      stq_rotated_executed[i]      = m_ex[j];
      stq_rotated_committed[i]     = m_cm[j];
      stq_rotated_address_valid[i] = m_av[j];
      stq_rotated_data_valid[i]    = m_dv[j];
      stq_valid[i]   = m_v[i];
      stq_address[i] = m_addr[i];
      stq_data[i]    = m_data[i];
      stq_rob_tag[i] = m_tag[i];
    end
    sq_head       = IW'(hd);
    mem_req_ready = rdy;
  endtask

  // One clock: drive, observe the queue-side effects at negedge, then act as memory.
  task automatic step();
    drive();
    @(negedge clk);
    if (store_fired === 1'b1) begin
      m_ex[store_fired_index] = 1;
      pending = 1;
      delay = $urandom_range(0, 3);
    end
    if (store_succeeded === 1'b1) begin
      m_v[hd] = 0; m_ex[hd] = 0; m_cm[hd] = 0;
      hd = (hd + 1) % N;
      cnt--;
    end
    @(posedge clk);
    #1;
    if (pending) begin
      if (hold_resp) mem_resp_valid = 0;
      else if (delay == 0) begin mem_resp_valid = 1; pending = 0; end
      else begin delay--; mem_resp_valid = 0; end
    end else begin
      mem_resp_valid = ($urandom_range(0, 99) < spur_pct);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((fire_q.size() != 0 || tag_q.size() != 0 || pending || cnt != 0) && n < budget) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, 64'(n >= budget), 64'(0));
  endtask

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      mon_retired = 0;
      tag_q.delete();
    end else begin
      check("fire_is_handshake", 64'(store_fired), 64'(mem_req_valid & mem_req_ready));
      check("fire_succ_overlap", 64'(store_fired & store_succeeded), 64'(0));
      if (mem_req_valid) begin
        check("busy_in_req", 64'(busy), 64'(1));
        if (fire_q.size() == 0) begin
          check("unexpected_req", 64'(1), 64'(0));
        end else begin
          check("req_addr", 64'(mem_req_addr), 64'(fire_q[0].addr));
          check("req_data", 64'(mem_req_data), 64'(fire_q[0].data));
          if (store_fired) begin
            check("fired_index", 64'(store_fired_index), 64'(fire_q[0].idx));
            check("fired_entry_ready",
                  64'(m_cm[fire_q[0].idx] & m_av[fire_q[0].idx] & m_dv[fire_q[0].idx]), 64'(1));
            tag_q.push_back(fire_q[0].tag);
            void'(fire_q.pop_front());
          end
        end
      end
      if (store_succeeded) begin
        mon_retired++;
        if (tag_q.size() == 0) check("unexpected_succeeded", 64'(1), 64'(0));
        else check("succeeded_tag", 64'(store_succeeded_rob_tag), 64'(tag_q.pop_front()));
      end
      check("stores_retired", 64'(stores_retired), 64'(mon_retired));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; mem_resp_valid = 0; rdy = 0; hold_resp = 0; spur_pct = 0;
    clear_model(0);
    drive();
    step(); step();
    check("rst_req_valid", 64'(mem_req_valid), 64'(0));
    check("rst_addr", 64'(mem_req_addr), 64'(0));
    check("rst_data", 64'(mem_req_data), 64'(0));
    check("rst_fired", 64'(store_fired), 64'(0));
    check("rst_fired_idx", 64'(store_fired_index), 64'(0));
    check("rst_succ", 64'(store_succeeded), 64'(0));
    check("rst_succ_tag", 64'(store_succeeded_rob_tag), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_retired", 64'(stores_retired), 64'(0));
    reset = 0;

    // Single store at head 0
    rdy = 1;
    alloc(32'h100, 32'hDEADBEEF, 8'd5, 1, 1, 1);
    wait_drain("basic", 50);
    check("basic_retired", 64'(stores_retired), 64'(1));

    // Younger ready store must wait for the uncommitted older one
    clear_model(6);
    alloc(32'h600, 32'h0606_0606, 8'd16, 0, 1, 1);
    alloc(32'h700, 32'h0707_0707, 8'd17, 1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step();
      check("no_bypass", 64'(mem_req_valid), 64'(0));
    end
    m_cm[6] = 1;
    wait_drain("in_order", 60);

    // Wrap from slot 7 to slot 0
    clear_model(7);
    alloc(32'h1234_5677, 32'hAAAA_0007, 8'd33, 1, 1, 1);
    alloc(32'h1234_5679, 32'hBBBB_0000, 8'd34, 1, 1, 1);
    wait_drain("wrap", 60);

    // Backpressure
    clear_model(2);
    rdy = 0;
    alloc(32'hCAFE_0001, 32'h5555_AAAA, 8'd40, 1, 1, 1);
    for (int i = 0; i < 7; i++) step();
    check("stall_req_valid", 64'(mem_req_valid), 64'(1));
    check("stall_no_fire", 64'(store_fired), 64'(0));
    rdy = 1;
    wait_drain("stall", 40);

    // Reset while waiting for the response, then a stale response
    clear_model(3);
    hold_resp = 1;
    alloc(32'hBEEF_0000, 32'h0BAD_F00D, 8'd77, 1, 1, 1);
    for (int i = 0; i < 20 && !pending; i++) step();
    check("reset_test_reached_wait", 64'(pending), 64'(1));
    step();
    reset = 1;
    step();
    reset = 0;
    hold_resp = 0;
    clear_model(3);
    spur_pct = 100;
    step();
    spur_pct = 0;
    step(); step();
    check("post_rst_succ", 64'(store_succeeded), 64'(0));
    check("post_rst_busy", 64'(busy), 64'(0));
    check("post_rst_req", 64'(mem_req_valid), 64'(0));
    check("post_rst_retired", 64'(stores_retired), 64'(0));
    check("post_rst_tag", 64'(store_succeeded_rob_tag), 64'(0));

    // Spurious responses with an empty queue
    spur_pct = 100;
    step(); step();
    spur_pct = 0;
    step(); step();
    check("spur_no_succ", 64'(store_succeeded), 64'(0));
    check("spur_retired", 64'(stores_retired), 64'(0));

    // Randomized traffic
    clear_model($urandom_range(0, N - 1));
    spur_pct = 10;
    for (int c = 0; c < 1500; c++) begin
      if (cnt < N && $urandom_range(0, 99) < 40)
        alloc($urandom, $urandom, TW'($urandom), 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      for (int i = 0; i < N; i++) begin
        if (m_v[i] && $urandom_range(0, 99) < 30) m_av[i] = 1;
        if (m_v[i] && $urandom_range(0, 99) < 30) m_dv[i] = 1;
      end
      for (int k = 0; k < cnt; k++) begin
        int j;
        j = (hd + k) % N;
        if (!m_cm[j]) begin
          if ($urandom_range(0, 99) < 30) m_cm[j] = 1;
          break;
        end
      end
      rdy = ($urandom_range(0, 99) < 70);
      step();
    end
    for (int i = 0; i < N; i++)
      if (m_v[i]) begin m_cm[i] = 1; m_av[i] = 1; m_dv[i] = 1; end
    rdy = 1;
    spur_pct = 0;
    wait_drain("random", 200);
    check("random_retired_total", 64'(stores_retired), 64'(mon_retired));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
